// File: rtl/riscv_lsu.sv
// riscv_lsu
// Load/store unit for the execute stage. Takes the decoder's memory controls,
// the ALU address and rs2 store data. It drives a req/gnt/rvalid data-memory
// port and stalls the core until the access completes. Loads return
// sign- or zero-extended data for write-back.
//
// Ports
//   clk_i, rst_i         core clock, synchronous active-high reset
//   lsu_req_i/we_i/size_i/addr_i/data_i
//                        request from the decoder/ALU (held while stalled)
//   lsu_stall_req_o      core stall while an accepted access is outstanding
//   lsu_data_o           extended load data, valid in the load completion cycle
//   lsu_misaligned_o     one-cycle flag for a misaligned/unsupported request
//   data_req_o/gnt_i/rvalid_i/rdata_i/we_o/be_o/addr_o/wdata_o
//                        data-memory port
module riscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_misaligned_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } state_t;

  state_t      state_r, state_next_s;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic        we_q;

  logic        latch_s;
  logic        req_s;
  logic        stall_s;
  logic        misaligned_s;
  logic [31:0] rdata_ext_s;

  // Size 2 (W) needs word alignment, H/HU halfword alignment; 3, 6, 7 are unsupported.
  function automatic logic req_legal(input logic [2:0] size, input logic [1:0] off);
    logic legal;
    case (size)
      3'd0, 3'd4: legal = 1'b1;
      3'd1, 3'd5: legal = ~off[0];
      3'd2:       legal = (off == 2'b00);
      default:    legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      3'd0, 3'd4: be = 4'b0001 << off;
      3'd1, 3'd5: be = 4'b0011 << {off[1], 1'b0};
      3'd2:       be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate narrow store data so every byte lane carries it.
  function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      3'd0, 3'd4: w = {4{d[7:0]}};
      3'd1, 3'd5: w = {2{d[15:0]}};
      default:    w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] size, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      3'd0:    r = {{24{b[7]}}, b};
      3'd4:    r = {24'd0, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd5:    r = {16'd0, h};
      3'd2:    r = rdata;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Next-state and per-state control decode.
  always_comb begin
    state_next_s = state_r;
    latch_s      = 1'b0;
    req_s        = 1'b0;
    stall_s      = 1'b0;
    misaligned_s = 1'b0;
    rdata_ext_s  = 32'd0;
    case (state_r)
      IDLE: begin
        if (lsu_req_i) begin
          if (req_legal(lsu_size_i, lsu_addr_i[1:0])) begin
            latch_s = 1'b1;
            req_s   = 1'b1;
            stall_s = 1'b1;
            if (data_gnt_i) begin
              state_next_s = WAIT_RVALID;
            end else begin
              state_next_s = WAIT_GNT;
            end
          end else begin
            misaligned_s = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT_GNT: begin
        req_s   = 1'b1;
        stall_s = 1'b1;
        if (data_gnt_i) begin
          state_next_s = WAIT_RVALID;
        end else begin
          state_next_s = WAIT_GNT;
        end
      end
      WAIT_RVALID: begin
        // A grant seen here is ignored; only rvalid moves the FSM on.
        if (data_rvalid_i) begin
          state_next_s = IDLE;
          if (we_q) begin
            rdata_ext_s = 32'd0;
          end else begin
            rdata_ext_s = load_extract(size_q, off_q, data_rdata_i);
          end
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output drive; everything is held at zero while reset is asserted.
  always_comb begin
    lsu_stall_req_o  = 1'b0;
    lsu_data_o       = 32'd0;
    lsu_misaligned_o = 1'b0;
    data_req_o       = 1'b0;
    data_we_o        = 1'b0;
    data_be_o        = 4'b0000;
    data_addr_o      = 32'd0;
    data_wdata_o     = 32'd0;
    if (rst_i) begin
      lsu_stall_req_o = 1'b0;
    end else begin
      lsu_stall_req_o  = stall_s;
      lsu_data_o       = rdata_ext_s;
      lsu_misaligned_o = misaligned_s;
      data_req_o       = req_s;
      if (req_s) begin
        // Address phase is driven from the live inputs the core holds stable.
        data_we_o    = lsu_we_i;
        data_be_o    = byte_enable(lsu_size_i, lsu_addr_i[1:0]);
        data_addr_o  = {lsu_addr_i[31:2], 2'b00};
        data_wdata_o = store_data(lsu_size_i, lsu_data_i);
      end else begin
        data_we_o = 1'b0;
      end
    end
  end

  // State register and request attribute latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (latch_s) begin
        size_q <= lsu_size_i;
        off_q  <= lsu_addr_i[1:0];
        we_q   <= lsu_we_i;
      end
    end
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit sitting directly downstream of the instruction decoder in the execute stage. It consumes the decoder's memory controls (`mem_req`, `mem_we`, `mem_size`) together with the ALU-computed address and the rs2 store data. It drives a req/gnt/rvalid data-memory port and stalls the core until each access completes. On loads it returns sign- or zero-extended data for write-back.

## Interface
Parameters:
- none; data and address widths are fixed at 32 bits.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- `clk_i`  in  1  core clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous active-high reset.
- `lsu_req_i`  in  1  access request, from decoder `mem_req_o`; held by the core while `lsu_stall_req_o`=1.
- `lsu_we_i`  in  1  1 = store, 0 = load (decoder `mem_we_o`).
- `lsu_size_i`  in  3  access size: 0=B, 1=H, 2=W, 4=BU, 5=HU (decoder `mem_size_o`).
- `lsu_addr_i`  in  32  byte address, from the ALU result.
- `lsu_data_i`  in  32  store data (rs2).
- `lsu_stall_req_o`  out  1  core stall; high while an accepted access has not completed.
- `lsu_data_o`  out  32  extended load result; valid only in the completion cycle of a load.
- `lsu_misaligned_o`  out  1  one-cycle flag: misaligned or unsupported-size request, which was not issued.
- `data_req_o`  out  1  memory request.
- `data_gnt_i`  in  1  memory grant; the address phase ends in the cycle `data_req_o` & `data_gnt_i`.
- `data_rvalid_i`  in  1  response valid; ends the data phase for both loads and stores.
- `data_rdata_i`  in  32  read data, sampled when `data_rvalid_i`=1.
- `data_we_o`  out  1  write enable.
- `data_be_o`  out  4  byte enables.
- `data_addr_o`  out  32  word address: {`lsu_addr_i`[31:2], 2'b00}.
- `data_wdata_o`  out  32  replicated store data.

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID. Reset state is IDLE.
- Request attribute latch: `size_q` (3 bits), `off_q` (2 bits, = `lsu_addr_i`[1:0]) and `we_q`. These load in IDLE when a legal request is issued.

IDLE with `lsu_req_i`=1:
- The request is legal if the size is W with addr[1:0]=0, H/HU with addr[0]=0, or B/BU.
- Sizes 3, 6 and 7 are unsupported.
- Illegal or unsupported request:
  - `data_req_o`=0.
  - `lsu_misaligned_o`=1 and `lsu_stall_req_o`=0 for that cycle.
  - `lsu_data_o`=0.
  - Stay in IDLE.
- Legal request:
  - `data_req_o`=1 and `lsu_stall_req_o`=1, both combinational.
  - If `data_gnt_i`=1, go to WAIT_RVALID; otherwise go to WAIT_GNT.

WAIT_GNT:
- `data_req_o`=1 and stall=1.
- Address, byte enables and write data are driven from the live inputs, which the core holds stable.
- On `data_gnt_i`=1, go to WAIT_RVALID.

WAIT_RVALID:
- `data_req_o`=0.
- When `data_rvalid_i`=1:
  - stall=0.
  - `lsu_data_o` is driven.
  - Go to IDLE.
- Otherwise stall=1.

Byte enables:
- B/BU: 4'b0001 << addr[1:0].
- H/HU: 4'b0011 << {addr[1], 1'b0}.
- W: 4'b1111.

Store data:
- B: {4{d[7:0]}}.
- H: {2{d[15:0]}}.
- W: d.

Load extract: uses `off_q`/`size_q` applied to `data_rdata_i`.
- B selects byte `off_q` and sign-extends it; BU selects the same byte and zero-extends it.
- H selects halfword `off_q[1]` and sign-extends it; HU selects the same halfword and zero-extends it.
- W passes the word through.

Stores:
- `lsu_data_o`=0.
- Completion still waits for `data_rvalid_i`.

## Timing
- Reset values:
  - state=IDLE; `size_q`=0, `off_q`=0, `we_q`=0.
  - While `rst_i`=1, all outputs are forced to 0: `data_req_o`, `lsu_stall_req_o`, `lsu_misaligned_o`, `data_we_o`, `data_be_o`, `data_addr_o`, `data_wdata_o`, `lsu_data_o`.
- Latency:
  - Minimum of 2 cycles (gnt in the request cycle, rvalid the next cycle).
  - The stall is high for (cycles to gnt) + (cycles to rvalid) − 1.
- Back-to-back accesses: a new `lsu_req_i` in the cycle after completion is accepted from IDLE. There are no bubbles beyond the FSM return.
- `data_rvalid_i` seen in IDLE or WAIT_GNT is ignored. This covers a stale response after a reset mid-access.
- Reset mid-access (WAIT_GNT or WAIT_RVALID): the block is in IDLE the next cycle, with stall=0.
- `lsu_req_i` dropping in WAIT_* is a core protocol violation. The FSM still completes the outstanding access.
- gnt and rvalid asserted in the same cycle in WAIT_RVALID: only rvalid is acted on.

## Test plan
- LW, addr 0x100, gnt same cycle, rvalid +1, rdata 0xDEADBEEF:
  - `data_be_o`=4'hF, `data_addr_o`=0x100.
  - Stall high 1 cycle.
  - `lsu_data_o`=0xDEADBEEF on completion.
- LB / LBU at addr 0x103, rdata 0x80FF_1234:
  - LB gives 0xFFFFFF80; LBU gives 0x00000080.
  - `data_be_o`=4'b1000.
- SH, addr 0x202, data 0x0000ABCD:
  - `data_be_o`=4'b1100, `data_wdata_o`=0xABCDABCD, `data_we_o`=1, `data_addr_o`=0x200.
  - Gnt delayed 3 cycles, rvalid +2: `data_req_o` held 4 cycles, stall high 5 cycles.
- LW at 0x102 and LH at 0x101:
  - `data_req_o` stays 0.
  - `lsu_misaligned_o`=1 for 1 cycle with no stall.
- Reset in WAIT_RVALID, then rvalid 1 cycle after reset release:
  - FSM in IDLE, stall 0, response ignored.
  - The next LW completes normally.
- Two back-to-back LHU requests (0x10, 0x12), rdata 0x8001_7FFE:
  - First returns 0x00007FFE, second returns 0x00008001.
  - Each takes 2 cycles.
